// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states
// and the byte-enable / lane helpers used by lsu_align.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } lsu_state_t;

    // The decoder never emits 2'b11, but it is folded onto a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_WORD : size;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] ofs);
        case (size)
            SIZE_BYTE: return 4'b0001 << ofs;
            SIZE_HALF: return 4'b0011 << {ofs[1], 1'b0};
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] align_addr(input logic [1:0] size,
                                               input logic [31:0] addr);
        case (size)
            SIZE_BYTE: return addr;
            SIZE_HALF: return {addr[31:1], 1'b0};
            default:   return {addr[31:2], 2'b00};
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] ofs);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return ofs[0];
            default:   return (ofs != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] lane_extend(input logic [1:0]  size,
                                                input logic [1:0]  ofs,
                                                input logic        is_unsigned,
                                                input logic [31:0] rdata);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [7:0]  b;
        logic [15:0] h;
        byte_sh = rdata >> {ofs, 3'b000};
        half_sh = rdata >> {ofs[1], 4'b0000};
        b = byte_sh[7:0];
        h = half_sh[15:0];
        case (size)
            SIZE_BYTE: return is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_HALF: return is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default:   return rdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// Single-outstanding request/grant/rvalid data bus between the LSU and memory.
interface lsu_bus_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Lane logic shared by both paths: byte enables and store replication on the
// way out, lane select plus sign/zero extension on the way back.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  ofs,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    always_comb begin
        be        = byte_enable(size, ofs);
        rdata_ext = lane_extend(size, ofs, is_unsigned, rdata);
        case (size)
            SIZE_BYTE: wdata_rep = {4{wdata[7:0]}};
            SIZE_HALF: wdata_rep = {2{wdata[15:0]}};
            default:   wdata_rep = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit driving a single-outstanding bus.
// Optional feature: LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_misaligned,
    lsu_bus_if.master   bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state;
    lsu_state_t  state_nx;

    logic        access;
    logic        mis_access;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic [CNT_W-1:0] cnt;

    logic        timeout_hit;
    logic        gnt_hit;
    logic        resp_hit;
    logic        enter_done;

    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic [31:0] rdata_q;
    logic        err_q;

    assign access   = i_valid && (i_load || i_store);
    assign acc_size = norm_size(i_size);

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign acc_addr     = i_addr;
    assign mis_access   = is_misaligned(acc_size, i_addr[1:0]);
    assign o_misaligned = mis_q;
`else
    assign acc_addr     = align_addr(acc_size, i_addr);
    assign mis_access   = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((state == REQ) || (state == RESP))
                         && (cnt == CNT_LIMIT);
    assign gnt_hit     = (state == REQ) && bus.gnt;
    assign resp_hit    = (state == RESP) && bus.rvalid;
    assign enter_done  = (state != DONE) && (state_nx == DONE);

    lsu_align u_align (
        .size        (size_q),
        .ofs         (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (bus.rdata),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant beats timeout in REQ and rvalid beats timeout in RESP.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (access) begin
                    state_nx = mis_access ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus.gnt) begin
                    state_nx = we_q ? DONE : RESP;
                end else if (timeout_hit) begin
                    state_nx = DONE;
                end
            end
            RESP: begin
                if (bus.rvalid || timeout_hit) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_stall   = !i_rst && (((state == IDLE) && access) || (state == REQ) || (state == RESP));
        o_done    = (state == DONE);
        o_rdata   = rdata_q;
        o_err     = err_q;
        bus.req   = (state == REQ);
        bus.we    = (state == REQ) && we_q;
        bus.addr  = (state == REQ) ? {addr_q[31:2], 2'b00} : '0;
        bus.be    = (state == REQ) ? be : '0;
        bus.wdata = (state == REQ) ? wdata_rep : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            if ((state == IDLE) && access) begin
                addr_q  <= acc_addr;
                wdata_q <= i_wdata;
                size_q  <= acc_size;
                uns_q   <= i_unsigned;
                we_q    <= i_store;
            end
            if ((state == REQ) || (state == RESP)) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (enter_done) begin
                rdata_q <= resp_hit ? rdata_ext : '0;
                err_q   <= timeout_hit && !resp_hit && !gnt_hit;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_q   <= (state == IDLE);
`endif
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; a second instance with a
// short timeout exercises the bus-timeout path.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        valid2;
    logic        load;
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        stall, done, err, mis;
    logic [31:0] rdata;
    logic        stall2, done2, err2, mis2;
    logic [31:0] rdata2;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    lsu_bus_if bus ();
    lsu_bus_if bus2 ();

    load_store_unit u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_load       (load),
        .i_store      (store),
        .i_size       (size),
        .i_unsigned   (uns),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .o_done       (done),
        .o_rdata      (rdata),
        .o_err        (err),
        .o_misaligned (mis),
        .bus          (bus)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid2),
        .i_load       (load),
        .i_store      (store),
        .i_size       (size),
        .i_unsigned   (uns),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall2),
        .o_done       (done2),
        .o_rdata      (rdata2),
        .o_err        (err2),
        .o_misaligned (mis2),
        .bus          (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept cycle; returns one cycle later with the inputs idle.
    task automatic issue(input string tag, input logic ld, input logic st,
                         input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd);
        valid = 1'b1;
        load  = ld;
        store = st;
        size  = sz;
        uns   = un;
        addr  = a;
        wdata = wd;
        #1;
        check({tag, "_accept_stall"}, stall, 1);
        step();
        valid = 1'b0;
        load  = 1'b0;
        store = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] exp_be, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata);
        issue(tag, 1'b0, 1'b1, sz, 1'b0, a, wd);
        check({tag, "_req"},   bus.req,   1);
        check({tag, "_we"},    bus.we,    1);
        check({tag, "_be"},    bus.be,    exp_be);
        check({tag, "_addr"},  bus.addr,  exp_addr);
        check({tag, "_wdata"}, bus.wdata, exp_wdata);
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        check({tag, "_done"},  done,    1);
        check({tag, "_stall"}, stall,   0);
        check({tag, "_err"},   err,     0);
        check({tag, "_req_drop"}, bus.req, 0);
        step();
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [3:0] exp_be, input logic [31:0] exp_addr,
                           input logic [31:0] exp_rdata);
        issue(tag, 1'b1, 1'b0, sz, un, a, 32'h5555_5555);
        check({tag, "_req"},  bus.req,  1);
        check({tag, "_we"},   bus.we,   0);
        check({tag, "_be"},   bus.be,   exp_be);
        check({tag, "_addr"}, bus.addr, exp_addr);
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        check({tag, "_resp_stall"}, stall,   1);
        check({tag, "_resp_req"},   bus.req, 0);
        check({tag, "_resp_done"},  done,    0);
        bus.rvalid = 1'b1;
        bus.rdata  = rd;
        step();
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        check({tag, "_done"},  done,  1);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"},   err,   0);
        check({tag, "_stall"}, stall, 0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0; valid2 = 1'b0; load = 1'b0; store = 1'b0;
        size = '0; uns = 1'b0; addr = '0; wdata = '0;
        bus.gnt = 1'b0;  bus.rvalid = 1'b0;  bus.rdata = '0;
        bus2.gnt = 1'b0; bus2.rvalid = 1'b0; bus2.rdata = '0;
        repeat (2) step();
        check("rst_stall", stall, 0);
        check("rst_done",  done,  0);
        check("rst_req",   bus.req, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err",   err,   0);
        check("rst_mis",   mis,   0);
        rst = 1'b0;
        step();

        do_store("st_byte", 2'b00, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'h0000_1000, 32'hABAB_ABAB);
        do_store("st_half", 2'b01, 32'h0000_8002, 32'h1234_BEEF, 4'b1100, 32'h0000_8000, 32'hBEEF_BEEF);
        do_load("ld_half_s", 2'b01, 1'b0, 32'h0000_2002, 32'h8001_1234, 4'b1100, 32'h0000_2000, 32'hFFFF_8001);
        do_load("ld_half_u", 2'b01, 1'b1, 32'h0000_2002, 32'h8001_1234, 4'b1100, 32'h0000_2000, 32'h0000_8001);
        do_load("ld_byte_s", 2'b00, 1'b0, 32'h0000_9001, 32'h0000_8000, 4'b0010, 32'h0000_9000, 32'hFFFF_FF80);
        do_load("ld_byte_u", 2'b00, 1'b1, 32'h0000_9001, 32'h0000_8000, 4'b0010, 32'h0000_9000, 32'h0000_0080);

        // Word load: grant held off for three REQ cycles, rvalid two cycles after grant.
        issue("ld_slow", 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_4000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("ld_slow_req",   bus.req,  1);
            check("ld_slow_stall", stall,    1);
            check("ld_slow_addr",  bus.addr, 32'h0000_4000);
            check("ld_slow_be",    bus.be,   4'b1111);
            if (i == 3) bus.gnt = 1'b1;
            step();
        end
        bus.gnt = 1'b0;
        check("ld_slow_resp1_stall", stall, 1);
        step();
        check("ld_slow_resp2_stall", stall, 1);
        check("ld_slow_resp2_done",  done,  0);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hDEAD_BEEF;
        step();
        bus.rvalid = 1'b0;
        check("ld_slow_done",  done,  1);
        check("ld_slow_rdata", rdata, 32'hDEAD_BEEF);
        check("ld_slow_err",   err,   0);
        step();
        check("ld_slow_hold_rdata", rdata, 32'hDEAD_BEEF);

        // Timeout on the 4-cycle instance: grant never arrives.
        valid2 = 1'b1; load = 1'b1; size = 2'b10; addr = 32'h0000_5000;
        step();
        valid2 = 1'b0; load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_req",  bus2.req, 1);
            check("to_done", done2,    0);
            step();
        end
        check("to_done_pulse", done2,    1);
        check("to_err",        err2,     1);
        check("to_rdata",      rdata2,   0);
        check("to_req_drop",   bus2.req, 0);
        check("to_stall",      stall2,   0);
        step();

`ifdef LSU_MISALIGN_TRAP_EN
        issue("mis_word", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0);
        check("mis_word_done",  done,    1);
        check("mis_word_flag",  mis,     1);
        check("mis_word_req",   bus.req, 0);
        check("mis_word_stall", stall,   0);
        check("mis_word_rdata", rdata,   0);
        step();
        do_load("ld_after_mis", 2'b10, 1'b0, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111, 32'h0000_3000, 32'hCAFE_F00D);
        check("ld_after_mis_flag", mis, 0);
`else
        do_load("mis_word", 2'b10, 1'b0, 32'h0000_3002, 32'hCAFE_F00D, 4'b1111, 32'h0000_3000, 32'hCAFE_F00D);
        check("mis_word_flag", mis, 0);
`endif

        // Reset while waiting in RESP; the late rvalid must be ignored.
        issue("rst_ld", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
        bus.gnt = 1'b1;
        step();
        bus.gnt = 1'b0;
        check("rst_ld_in_resp", stall, 1);
        rst = 1'b1;
        #1;
        check("rst_ld_stall", stall,    0);
        check("rst_ld_req",   bus.req,  0);
        check("rst_ld_addr",  bus.addr, 0);
        check("rst_ld_done",  done,     0);
        check("rst_ld_rdata", rdata,    0);
        #2;
        rst = 1'b0;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1111_2222;
        step();
        bus.rvalid = 1'b0;
        check("rst_late_done",  done,    0);
        check("rst_late_stall", stall,   0);
        check("rst_late_req",   bus.req, 0);
        step();
        check("rst_late_done2", done,  0);
        check("rst_late_rdata", rdata, 0);
        do_store("st_after_rst", 2'b10, 32'h0000_7000, 32'h1234_5678, 4'b1111, 32'h0000_7000, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
